gestor_objetos_n: RTL and testbench

//  Parametrised N-slot falling-object manager for the Canasta game; successor to the five fixed Cubo

---
 rtl/gestor_objetos_n_pkg.sv | 18 +
 rtl/gestor_objetos_n_ranura.sv | 104 ++++++++++
 rtl/gestor_objetos_n.sv | 166 ++++++++++++++++
 tb/tb_gestor_objetos_n.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gestor_objetos_n_pkg.sv
// Shared constants for the Canasta falling-object manager: geometry defaults,
// game FSM encodings and the x-distance helper used by the spawn spacing check.
package gestor_objetos_n_pkg;

  localparam int OBJ_SIZE_DEF = 16;
  localparam int BASKET_W_DEF = 64;
  localparam int Y_MAX_DEF    = 479;
  localparam int SCREEN_W     = 640;

  localparam logic [1:0] EST_INACTIVO = 2'b00;
  localparam logic [1:0] EST_JUEGO    = 2'b01;
  localparam logic [1:0] EST_FIN      = 2'b10;

  function automatic logic [9:0] dist_x(input logic [9:0] a, input logic [9:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/gestor_objetos_n_ranura.sv
// One object slot: position/colour/speed registers, per-frame fall,
// basket catch / floor miss evaluation and the pixel hit test.
module ranura_objeto
  import gestor_objetos_n_pkg::*;
#(
  parameter int OBJ_SIZE = OBJ_SIZE_DEF,
  parameter int BASKET_W = BASKET_W_DEF,
  parameter int Y_MAX    = Y_MAX_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cargar,
  input  logic       tick_frame,
  input  logic       evaluar,
  input  logic [9:0] x_in,
  input  logic [7:0] color_in,
  input  logic [1:0] vel_in,
  input  logic [9:0] canasta_x,
  input  logic [8:0] canasta_y,
  input  logic [9:0] pixel_x,
  input  logic [9:0] pixel_y,
  output logic       activo,
  output logic [9:0] x,
  output logic [7:0] color,
  output logic [1:0] vel,
  output logic       captura,
  output logic       fallo,
  output logic       hit
);

  logic       activo_d, activo_q;
  logic [9:0] x_d, x_q;
  logic [9:0] y_d, y_q;
  logic [7:0] color_d, color_q;
  logic [1:0] vel_d, vel_q;

  logic [10:0] y_bot, x_der, cx, cy, cx_der, y_sum;
  logic [9:0]  y_mov;
  logic        en_canasta;

  // All geometry is compared in 11 bits so bottom/right edges never wrap.
  always_comb begin
    y_bot  = {1'b0, y_q} + 11'(OBJ_SIZE);
    x_der  = {1'b0, x_q} + 11'(OBJ_SIZE);
    cx     = {1'b0, canasta_x};
    cy     = {2'b00, canasta_y};
    cx_der = cx + 11'(BASKET_W);
    y_sum  = {1'b0, y_q} + {9'd0, vel_q} + 11'd1;
    y_mov  = y_sum[10] ? 10'h3FF : y_sum[9:0];

    en_canasta = (y_bot >= cy) && ({1'b0, y_q} <= cy) &&
                 (x_der > cx) && ({1'b0, x_q} < cx_der);
    captura = activo_q && evaluar && en_canasta;
    fallo   = activo_q && evaluar && !en_canasta && (y_bot > 11'(Y_MAX));

    hit = activo_q &&
          ({1'b0, pixel_x} >= {1'b0, x_q}) && ({1'b0, pixel_x} < x_der) &&
          ({1'b0, pixel_y} >= {1'b0, y_q}) && ({1'b0, pixel_y} < y_bot);
  end

  always_comb begin
    // NOTE: every _d starts from its _q so no branch can leave a latch behind.
    activo_d = activo_q;
    x_d      = x_q;
    y_d      = y_q;
    color_d  = color_q;
    vel_d    = vel_q;
    if (cargar) begin
      activo_d = 1'b1;
      x_d      = x_in;
      y_d      = '0;
      color_d  = color_in;
      vel_d    = vel_in;
    end else if (captura || fallo) begin
      activo_d = 1'b0;
    end else if (activo_q && tick_frame) begin
      y_d = y_mov;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: slot state is a handful of flops, not a RAM, so reset clears all of it.
    if (reset) begin
      activo_q <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      color_q  <= '0;
      vel_q    <= '0;
    end else begin
      // NOTE: non-blocking only here, so every slot samples the same pre-edge values.
      activo_q <= activo_d;
      x_q      <= x_d;
      y_q      <= y_d;
      color_q  <= color_d;
      vel_q    <= vel_d;
    end
  end

  assign activo = activo_q;
  assign x      = x_q;
  assign color  = color_q;
  assign vel    = vel_q;

endmodule

// File: rtl/gestor_objetos_n.sv
// N-slot falling-object manager: game FSM, priority slot allocator with spacing
// check, saturating score/miss accumulation and registered pixel overlay.
module gestor_objetos_n
  import gestor_objetos_n_pkg::*;
#(
  parameter int N_OBJ    = 5,
  parameter int OBJ_SIZE = OBJ_SIZE_DEF,
  parameter int BASKET_W = BASKET_W_DEF,
  parameter int Y_MAX    = Y_MAX_DEF,
  parameter int SCORE_W  = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               fin_juego,
  input  logic               tick_spawn,
  input  logic               tick_frame,
  input  logic [9:0]         spawn_x,
  input  logic [7:0]         spawn_color,
  input  logic [1:0]         spawn_vel,
  input  logic [9:0]         canasta_x,
  input  logic [8:0]         canasta_y,
  input  logic [9:0]         pixel_x,
  input  logic [9:0]         pixel_y,
  output logic               pintar,
  output logic [7:0]         color,
  output logic [N_OBJ-1:0]   ocupados,
  output logic [SCORE_W-1:0] puntaje,
  output logic               pulso_captura,
  output logic [7:0]         fallos,
  output logic [1:0]         estado
);

  localparam int SUM_W = SCORE_W + 8;

  logic [N_OBJ-1:0] activo, captura, fallo, hit, cargar;
  logic [9:0]       x_arr   [N_OBJ];
  logic [7:0]       col_arr [N_OBJ];
  logic [1:0]       vel_arr [N_OBJ];

  logic [1:0]         estado_d, estado_q;
  logic [SCORE_W-1:0] puntaje_d, puntaje_q;
  logic [7:0]         fallos_d, fallos_q;
  logic               pulso_d, pulso_q;
  logic               evaluar_d, evaluar_q;
  logic               pintar_d, pintar_q;
  logic [7:0]         color_d, color_q;

  logic             conflicto, fuera, aceptar, asignado;
  logic [6:0]       puntos;
  logic [4:0]       n_fallos;
  logic [SUM_W-1:0] suma;
  logic [8:0]       suma_fallos;

  for (genvar g = 0; g < N_OBJ; g++) begin : g_ranura
    ranura_objeto #(
      .OBJ_SIZE (OBJ_SIZE),
      .BASKET_W (BASKET_W),
      .Y_MAX    (Y_MAX)
    ) u_ranura (
      .clk        (clk),
      .reset      (reset),
      .cargar     (cargar[g]),
      .tick_frame (tick_frame),
      .evaluar    (evaluar_q),
      .x_in       (spawn_x),
      .color_in   (spawn_color),
      .vel_in     (spawn_vel),
      .canasta_x  (canasta_x),
      .canasta_y  (canasta_y),
      .pixel_x    (pixel_x),
      .pixel_y    (pixel_y),
      .activo     (activo[g]),
      .x          (x_arr[g]),
      .color      (col_arr[g]),
      .vel        (vel_arr[g]),
      .captura    (captura[g]),
      .fallo      (fallo[g]),
      .hit        (hit[g])
    );
  end

  // Spawn: reject on spacing clash or off-screen x, else lowest free slot wins.
  always_comb begin
    conflicto = 1'b0;
    for (int i = 0; i < N_OBJ; i++) begin
      if (activo[i] && (dist_x(spawn_x, x_arr[i]) < 10'(OBJ_SIZE))) conflicto = 1'b1;
    end
    fuera    = spawn_x > 10'(SCREEN_W - 1 - OBJ_SIZE);
    aceptar  = (estado_q == EST_JUEGO) && tick_spawn && !conflicto && !fuera;
    asignado = 1'b0;
    cargar   = '0;
    for (int i = 0; i < N_OBJ; i++) begin
      if (aceptar && !activo[i] && !asignado) begin
        cargar[i] = 1'b1;
        asignado  = 1'b1;
      end
    end
  end

  // All catches of one evaluation cycle land in a single saturating add.
  always_comb begin
    puntos   = '0;
    n_fallos = '0;
    for (int i = 0; i < N_OBJ; i++) begin
      if (captura[i]) puntos = puntos + 7'(vel_arr[i]) + 7'd1;
      n_fallos = n_fallos + 5'(fallo[i]);
    end
    suma        = SUM_W'(puntaje_q) + SUM_W'(puntos);
    suma_fallos = {1'b0, fallos_q} + 9'(n_fallos);

    puntaje_d = (suma > SUM_W'({SCORE_W{1'b1}})) ? '1 : suma[SCORE_W-1:0];
    fallos_d  = suma_fallos[8] ? 8'hFF : suma_fallos[7:0];
    pulso_d   = |captura;
    evaluar_d = tick_frame;
    estado_d  = estado_q;

    case (estado_q)
      EST_INACTIVO: if (start) begin
        estado_d  = EST_JUEGO;
        puntaje_d = '0;
        fallos_d  = '0;
      end
      EST_JUEGO:    if (fin_juego) estado_d = EST_FIN;
      EST_FIN:      if (activo == '0) estado_d = EST_INACTIVO;
      default:      estado_d = EST_INACTIVO;
    endcase
  end

  always_comb begin
    pintar_d = |hit;
    color_d  = '0;
    for (int i = N_OBJ - 1; i >= 0; i--) begin
      if (hit[i]) color_d = col_arr[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q  <= EST_INACTIVO;
      puntaje_q <= '0;
      fallos_q  <= '0;
      pulso_q   <= 1'b0;
      evaluar_q <= 1'b0;
      pintar_q  <= 1'b0;
      color_q   <= '0;
    end else begin
      estado_q  <= estado_d;
      puntaje_q <= puntaje_d;
      fallos_q  <= fallos_d;
      pulso_q   <= pulso_d;
      evaluar_q <= evaluar_d;
      pintar_q  <= pintar_d;
      color_q   <= color_d;
    end
  end

  assign ocupados      = activo;
  assign puntaje       = puntaje_q;
  assign fallos        = fallos_q;
  assign pulso_captura = pulso_q;
  assign estado        = estado_q;
  assign pintar        = pintar_q;
  assign color         = color_q;

endmodule

// File: tb/tb_gestor_objetos_n.sv
// Directed bench for gestor_objetos_n: spawn and overlay vector tables plus
// hand-written catch, miss, end-of-game and reset sequences.
module tb_gestor_objetos_n;

  logic       clk = 1'b0;
  logic       reset, start, fin_juego, tick_spawn, tick_frame;
  logic [9:0] spawn_x, canasta_x, pixel_x, pixel_y;
  logic [7:0] spawn_color;
  logic [1:0] spawn_vel;
  logic [8:0] canasta_y;
  logic       pintar, pulso_captura;
  logic [7:0] color, fallos;
  logic [4:0] ocupados;
  logic [9:0] puntaje;
  logic [1:0] estado;

  int n_pass = 0;
  int n_total = 0;
  int pulse_cnt = 0;

  typedef struct {
    logic [9:0] x;
    logic [7:0] col;
    logic [4:0] exp_ocup;
  } spawn_vec_t;

  typedef struct {
    logic [9:0] px;
    logic [9:0] py;
    logic       exp_pintar;
    logic [7:0] exp_color;
  } pix_vec_t;

  spawn_vec_t sv [9];
  pix_vec_t   pv [8];

  always #5 clk = ~clk;

  gestor_objetos_n dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .fin_juego     (fin_juego),
    .tick_spawn    (tick_spawn),
    .tick_frame    (tick_frame),
    .spawn_x       (spawn_x),
    .spawn_color   (spawn_color),
    .spawn_vel     (spawn_vel),
    .canasta_x     (canasta_x),
    .canasta_y     (canasta_y),
    .pixel_x       (pixel_x),
    .pixel_y       (pixel_y),
    .pintar        (pintar),
    .color         (color),
    .ocupados      (ocupados),
    .puntaje       (puntaje),
    .pulso_captura (pulso_captura),
    .fallos        (fallos),
    .estado        (estado)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (pulso_captura === 1'b1) pulse_cnt++;
  endtask

  task automatic pulse_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic spawn(input logic [9:0] x, input logic [7:0] col, input logic [1:0] vel);
    spawn_x = x; spawn_color = col; spawn_vel = vel; tick_spawn = 1'b1;
    step();
    tick_spawn = 1'b0;
  endtask

  // One frame: the move edge, then the evaluation edge.
  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      tick_frame = 1'b1; step();
      tick_frame = 1'b0; step();
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; step(); step(); reset = 1'b0;
  endtask

  initial begin
    sv[0] = '{10'd0,   8'h11, 5'b00001};
    sv[1] = '{10'd10,  8'h12, 5'b00001};  // too close to x=0
    sv[2] = '{10'd40,  8'h22, 5'b00011};
    sv[3] = '{10'd55,  8'h23, 5'b00011};  // |55-40| = 15
    sv[4] = '{10'd80,  8'h33, 5'b00111};
    sv[5] = '{10'd624, 8'h34, 5'b00111};  // right edge exceeded
    sv[6] = '{10'd120, 8'h44, 5'b01111};
    sv[7] = '{10'd160, 8'h55, 5'b11111};
    sv[8] = '{10'd200, 8'h66, 5'b11111};  // no free slot

    pv[0] = '{10'd5,   10'd5,  1'b1, 8'h11};
    pv[1] = '{10'd15,  10'd15, 1'b1, 8'h11};
    pv[2] = '{10'd16,  10'd0,  1'b0, 8'h00};
    pv[3] = '{10'd40,  10'd15, 1'b1, 8'h22};
    pv[4] = '{10'd39,  10'd0,  1'b0, 8'h00};
    pv[5] = '{10'd170, 10'd16, 1'b0, 8'h00};
    pv[6] = '{10'd175, 10'd15, 1'b1, 8'h55};
    pv[7] = '{10'd130, 10'd3,  1'b1, 8'h44};

    reset = 1'b1; start = 1'b0; fin_juego = 1'b0; tick_spawn = 1'b0; tick_frame = 1'b0;
    spawn_x = '0; spawn_color = '0; spawn_vel = '0;
    canasta_x = 10'd90; canasta_y = 9'd440; pixel_x = 10'd600; pixel_y = 10'd470;
    repeat (3) step();
    reset = 1'b0;
    step();
    check("rst_estado", 32'(estado), 32'd0);
    check("rst_ocupados", 32'(ocupados), 32'd0);
    check("rst_puntaje", 32'(puntaje), 32'd0);
    check("rst_fallos", 32'(fallos), 32'd0);
    check("rst_pintar", 32'(pintar), 32'd0);
    check("rst_color", 32'(color), 32'd0);
    check("rst_pulso", 32'(pulso_captura), 32'd0);

    spawn(10'd100, 8'hE0, 2'd0);
    check("spawn_in_inactivo", 32'(ocupados), 32'd0);
    fin_juego = 1'b1; step(); fin_juego = 1'b0;
    check("fin_in_inactivo", 32'(estado), 32'd0);

    // Catch: vel 0, basket y=440 -> caught once y reaches 424.
    pulse_start();
    check("start_estado", 32'(estado), 32'd1);
    spawn(10'd100, 8'hE0, 2'd0);
    check("catch_spawned", 32'(ocupados), 32'd1);
    frames(423);
    check("catch_not_yet", 32'(ocupados), 32'd1);
    check("catch_no_points", 32'(puntaje), 32'd0);
    frames(1);
    check("catch_freed", 32'(ocupados), 32'd0);
    check("catch_puntaje", 32'(puntaje), 32'd1);
    check("catch_pulse_now", 32'(pulso_captura), 32'd1);
    step();
    check("catch_pulse_gone", 32'(pulso_captura), 32'd0);
    check("catch_pulse_count", 32'(pulse_cnt), 32'd1);

    // Miss: vel 3, basket elsewhere -> y=464 after 116 frames.
    canasta_x = 10'd0;
    spawn(10'd300, 8'h1C, 2'd3);
    frames(115);
    check("miss_not_yet", 32'(ocupados), 32'd1);
    frames(1);
    check("miss_freed", 32'(ocupados), 32'd0);
    check("miss_fallos", 32'(fallos), 32'd1);
    check("miss_puntaje_kept", 32'(puntaje), 32'd1);

    for (int i = 0; i < 9; i++) begin
      spawn(sv[i].x, sv[i].col, 2'd0);
      check($sformatf("spawn_vec%0d", i), 32'(ocupados), 32'(sv[i].exp_ocup));
    end

    for (int i = 0; i < 8; i++) begin
      pixel_x = pv[i].px; pixel_y = pv[i].py;
      step();
      check($sformatf("pix_vec%0d_pintar", i), 32'(pintar), 32'(pv[i].exp_pintar));
      check($sformatf("pix_vec%0d_color", i), 32'(color), 32'(pv[i].exp_color));
    end

    do_reset();
    step();
    check("midreset_ocupados", 32'(ocupados), 32'd0);
    check("midreset_estado", 32'(estado), 32'd0);
    check("midreset_puntaje", 32'(puntaje), 32'd0);
    check("midreset_fallos", 32'(fallos), 32'd0);
    check("midreset_pintar", 32'(pintar), 32'd0);

    // Two vel-1 objects reach the basket on the same frame (y=424 at frame 212).
    canasta_x = 10'd90;
    pixel_x = 10'd600; pixel_y = 10'd470;
    pulse_start();
    spawn(10'd100, 8'h01, 2'd1);
    spawn(10'd130, 8'h02, 2'd1);
    check("dual_spawned", 32'(ocupados), 32'd3);
    pulse_cnt = 0;
    frames(211);
    check("dual_not_yet", 32'(puntaje), 32'd0);
    frames(1);
    check("dual_puntaje", 32'(puntaje), 32'd4);
    check("dual_freed", 32'(ocupados), 32'd0);
    step();
    check("dual_single_pulse", 32'(pulse_cnt), 32'd1);

    // End of game with two live objects.
    canasta_x = 10'd0;
    spawn(10'd300, 8'h03, 2'd3);
    spawn(10'd400, 8'h04, 2'd3);
    fin_juego = 1'b1; step(); fin_juego = 1'b0;
    check("fin_estado", 32'(estado), 32'd2);
    pulse_start();
    check("start_in_fin", 32'(estado), 32'd2);
    spawn(10'd500, 8'h05, 2'd0);
    check("spawn_in_fin", 32'(ocupados), 32'd3);
    frames(116);
    check("fin_freed", 32'(ocupados), 32'd0);
    check("fin_fallos", 32'(fallos), 32'd2);
    check("fin_puntaje_kept", 32'(puntaje), 32'd4);
    check("fin_still_fin", 32'(estado), 32'd2);
    step();
    check("fin_to_inactivo", 32'(estado), 32'd0);

    // Overlay latency with two adjacent objects.
    pulse_start();
    check("restart_puntaje", 32'(puntaje), 32'd0);
    check("restart_fallos", 32'(fallos), 32'd0);
    spawn(10'd100, 8'hE0, 2'd0);
    spawn(10'd116, 8'h03, 2'd0);
    pixel_x = 10'd100; pixel_y = 10'd0;
    #3;
    check("ovl_before_edge", 32'(pintar), 32'd0);
    step();
    check("ovl_red_pintar", 32'(pintar), 32'd1);
    check("ovl_red_color", 32'(color), 32'hE0);
    pixel_x = 10'd116;
    step();
    check("ovl_blue_color", 32'(color), 32'h03);
    pixel_x = 10'd115; pixel_y = 10'd15;
    step();
    check("ovl_red_edge", 32'(color), 32'hE0);

    do_reset();
    step();
    check("final_reset_ocupados", 32'(ocupados), 32'd0);
    check("final_reset_estado", 32'(estado), 32'd0);
    check("final_reset_color", 32'(color), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
